// File: rtl/gpio_filter.sv
// rtl/gpio_filter.sv - pad input synchronizer plus per-pin prescaled debounce filter
// Optional 2-flop din synchronizer enabled by defining GPIO_FILTER_SYNC_EN.
module gpio_filter #(
   parameter int N  = 24,
   parameter int CW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  cfg_en,
   input  logic [DW-1:0] cfg_div,
   input  logic [CW-1:0] cfg_thresh,
   input  logic [N-1:0]  din,
   output logic [N-1:0]  dout,
   output logic [N-1:0]  change
);

   logic [N-1:0]  s;
   logic [DW-1:0] presc_q, presc_d;
   logic          tick;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [N-1:0]  dout_q, dout_d;
   logic [N-1:0]  change_q;

`ifdef GPIO_FILTER_SYNC_EN
   logic [N-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = din;
`endif

   // >= rather than == so a lowered divisor fires immediately instead of wrapping
   assign tick    = (presc_q >= cfg_div);
   assign presc_d = tick ? '0 : presc_q + DW'(1);

   always_comb begin
      dout_d = dout_q;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!cfg_en[i]) begin
            dout_d[i] = s[i];
            cnt_d[i]  = '0;
         end else if (s[i] == dout_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] >= cfg_thresh) begin
               dout_d[i] = s[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q  <= '0;
         dout_q   <= '0;
         change_q <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         presc_q  <= presc_d;
         dout_q   <= dout_d;
         change_q <= dout_d ^ dout_q;
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign dout   = dout_q;
   assign change = change_q;

endmodule
